// File: rtl/hact_pkg.sv
// Shared types and sizing helpers for the accumulate-and-activate array.
package hact_pkg;

  typedef enum logic {
    HARDTANH = 1'b0,
    RELU     = 1'b1
  } act_mode_e;

  // Sized so that ADIM beats of all-ones can never overflow.
  function automatic int awid_f(input int iwid, input int adim);
    return iwid + $clog2(adim) + 1;
  endfunction

  function automatic int zero_point_f(input int iwid, input int adim);
    return adim * (1 << (iwid - 1));
  endfunction

endpackage

// File: rtl/hact_lane.sv
// One channel: frame accumulator, centring/shift, activation and output code register.
module hact_lane
  import hact_pkg::*;
#(
  parameter int IWID = 4,
  parameter int ADIM = 4,
  parameter int OWID = 4,
  parameter int SHFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_accept,
  input  logic            i_first,
  input  logic            i_last,
  input  act_mode_e       i_mode,
  input  logic [IWID-1:0] i_beat,
  output logic [OWID-1:0] o_code
);

  localparam int AWID = awid_f(IWID, ADIM);
  localparam int ZP   = zero_point_f(IWID, ADIM);
  // Signed working width wide enough for both the centred sum and the output limits.
  localparam int VW   = (AWID + 1 > OWID + 1) ? AWID + 1 : OWID + 1;

  localparam logic signed [VW-1:0] ZP_S   = VW'(ZP);
  localparam logic signed [VW-1:0] V_HI   = VW'((1 << (OWID - 1)) - 1);
  localparam logic signed [VW-1:0] V_LO   = VW'(-(1 << (OWID - 1)));
  localparam logic signed [VW-1:0] V_ZERO = '0;
  localparam logic [OWID-1:0]      C_MID  = OWID'(1 << (OWID - 1));

  logic [AWID-1:0]        r_acc;
  logic [AWID-1:0]        w_sum;
  logic signed [VW-1:0]   w_cent;
  logic signed [VW-1:0]   w_v;
  logic [OWID-1:0]        w_off;
  logic [OWID-1:0]        w_code;

  assign w_sum  = (i_first ? '0 : r_acc) + AWID'(i_beat);
  assign w_cent = $signed(VW'(w_sum)) - ZP_S;
  assign w_v    = w_cent >>> SHFT;
  assign w_off  = w_v[OWID-1:0] + C_MID;

  always_comb begin
    w_code = w_off;
    if (i_mode == HARDTANH) begin
      if (w_v >= V_HI)      w_code = '1;
      else if (w_v <= V_LO) w_code = '0;
    end else begin
      if (w_v <= V_ZERO)    w_code = C_MID;
      else if (w_v >= V_HI) w_code = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      o_code <= '0;
    end else if (i_accept) begin
      r_acc <= i_last ? '0 : w_sum;
      if (i_last) o_code <= w_code;
    end
  end

endmodule

// File: rtl/hact_acc_array.sv
// IDIM-channel beat accumulator with per-frame hardtanh/ReLU activation and a one-deep output stage.
module hact_acc_array
  import hact_pkg::*;
#(
  parameter int IDIM = 4,
  parameter int IWID = 4,
  parameter int ADIM = 4,
  parameter int OWID = 4,
  parameter int SHFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            act_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IWID-1:0] in_data  [IDIM],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OWID-1:0] out_data [IDIM]
);

  localparam int             CW       = $clog2(ADIM);
  localparam logic [CW-1:0]  CNT_LAST = CW'(ADIM - 1);

  logic [CW-1:0] r_cnt;
  act_mode_e     r_mode;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_first;
  logic          w_last;
  act_mode_e     w_mode;

  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CNT_LAST);
  // Only the last beat of a frame needs the output slot, so only it can stall.
  assign in_ready = !(w_last && r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_mode   = w_first ? act_mode_e'(act_mode) : r_mode;

  assign out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_mode      <= HARDTANH;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        if (w_first) r_mode <= act_mode_e'(act_mode);
      end
      if (w_accept && w_last) r_out_valid <= 1'b1;
      else if (out_ready)     r_out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < IDIM; g++) begin : g_lane
    hact_lane #(
      .IWID(IWID),
      .ADIM(ADIM),
      .OWID(OWID),
      .SHFT(SHFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_accept(w_accept),
      .i_first (w_first),
      .i_last  (w_last),
      .i_mode  (w_mode),
      .i_beat  (in_data[g]),
      .o_code  (out_data[g])
    );
  end

endmodule

// File: tb/tb_hact_acc_array.sv
// Self-checking bench: directed vector table, stall/reset/streaming sequences and a random run against a frame-level model.
module tb_hact_acc_array;

  localparam int IDIM = 4;
  localparam int IWID = 4;
  localparam int ADIM = 4;
  localparam int OWID = 4;
  localparam int SHFT = 0;
  localparam int ZP   = ADIM * (1 << (IWID - 1));

  typedef logic [IDIM-1:0][IWID-1:0] beat_t;
  typedef logic [IDIM-1:0][OWID-1:0] frame_t;

  typedef struct {
    beat_t            beats [ADIM];
    logic [ADIM-1:0]  modes;
    frame_t           exp;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            act_mode;
  logic            in_valid;
  logic            in_ready;
  logic [IWID-1:0] in_data  [IDIM];
  logic            out_valid;
  logic            out_ready;
  logic [OWID-1:0] out_data [IDIM];

  int n_checks = 0;
  int n_fail   = 0;

  hact_acc_array #(
    .IDIM(IDIM), .IWID(IWID), .ADIM(ADIM), .OWID(OWID), .SHFT(SHFT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .act_mode (act_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Activation straight from the arithmetic definition.
  function automatic logic [OWID-1:0] ref_act(input int s, input bit m);
    int v, hi, lo, mid;
    v   = (s - ZP) >>> SHFT;
    hi  = (1 << (OWID - 1)) - 1;
    lo  = -(1 << (OWID - 1));
    mid = 1 << (OWID - 1);
    if (!m) begin
      if (v >= hi) return OWID'((1 << OWID) - 1);
      if (v <= lo) return '0;
      return OWID'(v + mid);
    end
    if (v <= 0)  return OWID'(mid);
    if (v >= hi) return OWID'((1 << OWID) - 1);
    return OWID'(v + mid);
  endfunction

  // Frame-level model: beat count, per-channel sums, queue of pending results.
  bit     mon_en = 1'b0;
  int     m_cnt  = 0;
  int     m_acc [IDIM];
  bit     m_mode = 1'b0;
  frame_t m_q [$];

  always @(negedge clk) begin
    bit     exp_rdy;
    frame_t f;
    if (mon_en) begin
      exp_rdy = !(m_cnt == ADIM - 1 && m_q.size() > 0 && !out_ready);
      check("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("mon_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0 && out_valid)
        for (int c = 0; c < IDIM; c++) check("mon_out_data", 32'(out_data[c]), 32'(m_q[0][c]));
      if (rst) begin
        m_cnt = 0;
        for (int c = 0; c < IDIM; c++) m_acc[c] = 0;
        m_q.delete();
      end else begin
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (in_valid && exp_rdy) begin
          if (m_cnt == 0) m_mode = act_mode;
          for (int c = 0; c < IDIM; c++) m_acc[c] += int'(in_data[c]);
          if (m_cnt == ADIM - 1) begin
            for (int c = 0; c < IDIM; c++) begin
              f[c] = ref_act(m_acc[c], m_mode);
              m_acc[c] = 0;
            end
            m_q.push_back(f);
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input beat_t d, input bit m);
    for (int c = 0; c < IDIM; c++) in_data[c] = d[c];
    act_mode = m;
  endtask

  function automatic beat_t uni(input int x);
    beat_t b;
    for (int c = 0; c < IDIM; c++) b[c] = IWID'(x);
    return b;
  endfunction

  // Offers one beat and waits (bounded) until it is taken.
  task automatic drive_beat(input beat_t d, input bit m);
    bit ok;
    int n;
    in_valid = 1'b1;
    set_beat(d, m);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    check("beat_accept", 32'(ok), 32'd1);
  endtask

  vec_t vecs [11];

  task automatic set_vec(input int i, input int val, input logic [ADIM-1:0] modes, input frame_t exp);
    for (int b = 0; b < ADIM; b++) vecs[i].beats[b] = uni(val);
    vecs[i].modes = modes;
    vecs[i].exp   = exp;
  endtask

  initial begin
    int pulses, last;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(uni(0), 1'b0);

    set_vec(0,  15, 4'b0000, {4'd15, 4'd15, 4'd15, 4'd15});
    set_vec(1,   8, 4'b0000, {4'd8,  4'd8,  4'd8,  4'd13});
    for (int b = 0; b < ADIM; b++) vecs[1].beats[b][0] = (b == ADIM - 1) ? 4'd10 : 4'd9;
    set_vec(2,   0, 4'b0000, {4'd0,  4'd0,  4'd0,  4'd0});
    set_vec(3,   0, 4'b1111, {4'd8,  4'd8,  4'd8,  4'd8});
    set_vec(4,   0, 4'b1110, {4'd0,  4'd0,  4'd0,  4'd0});
    set_vec(5,   0, 4'b0001, {4'd8,  4'd8,  4'd8,  4'd8});
    set_vec(6,   7, 4'b0000, {4'd4,  4'd4,  4'd4,  4'd4});
    set_vec(7,   9, 4'b1111, {4'd12, 4'd12, 4'd12, 4'd12});
    set_vec(8,   6, 4'b0000, {4'd0,  4'd0,  4'd0,  4'd0});
    set_vec(9,  10, 4'b0000, {4'd15, 4'd15, 4'd15, 4'd15});
    vecs[9].beats[ADIM-1] = uni(9);
    set_vec(10,  8, 4'b1111, {4'd8,  4'd8,  4'd8,  4'd9});
    vecs[10].beats[0][0] = 4'd9;

    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < IDIM; c++) check("rst_out_data", 32'(out_data[c]), 32'd0);
    mon_en = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      for (int b = 0; b < ADIM; b++) drive_beat(vecs[i].beats[b], vecs[i].modes[b]);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      for (int c = 0; c < IDIM; c++)
        check($sformatf("vec%0d_data", i), 32'(out_data[c]), 32'(vecs[i].exp[c]));
      step();
    end

    // Output held across two frames: second frame's last beat must stall.
    out_ready = 1'b0;
    for (int b = 0; b < ADIM; b++) drive_beat(uni(9), 1'b0);
    for (int b = 0; b < ADIM - 1; b++) drive_beat(uni(7), 1'b0);
    in_valid = 1'b1;
    set_beat(uni(7), 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold_a", 32'(out_data[0]), 32'd12);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_a_data", 32'(out_data[2]), 32'd12);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("release_b_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < IDIM; c++) check("release_b_data", 32'(out_data[c]), 32'd4);
    step();
    @(negedge clk);
    check("release_empty", 32'(out_valid), 32'd0);
    step();

    // Reset mid-frame discards the partial sums.
    drive_beat(uni(3), 1'b1);
    drive_beat(uni(3), 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    for (int b = 0; b < ADIM; b++) drive_beat(uni(15), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < IDIM; c++) check("midrst_data", 32'(out_data[c]), 32'd15);
    step();

    // Streaming: one result per ADIM cycles, never back-pressured.
    pulses = 0;
    last   = -1;
    for (int k = 0; k < 40 * ADIM + 4; k++) begin
      if (k < 40 * ADIM) begin
        in_valid = 1'b1;
        for (int c = 0; c < IDIM; c++) in_data[c] = IWID'($urandom_range(0, (1 << IWID) - 1));
        act_mode = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 40 * ADIM) check("cont_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        pulses++;
        if (last >= 0) check("cont_spacing", 32'(k - last), 32'(ADIM));
        last = k;
      end
      step();
    end
    check("cont_frames", 32'(pulses), 32'd40);

    // Random traffic with back-pressure and occasional reset.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      act_mode  = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < IDIM; c++) in_data[c] = IWID'($urandom_range(0, (1 << IWID) - 1));
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
